uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several byte-stream requesters, such as the trace-buffer dump path, config acknowledgements and status reporting. Each grant is a burst: it lasts until the requester's last byte or until MAX_BURST bytes have been sent, and may start with a header byte that identifies the requester. The block sits between the requesters and the UART TX core, and drives the same tx_data / new_tx_data / tx_busy handshake the reconfig unit uses.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_BURST, 16, maximum payload bytes per grant before the requester is forced to re-arbitrate
HEADER_EN, 1, when 1, send header byte {4'hA, 1'b0, grant_id[2:0]} before each burst's payload
STALL_MAX, 1024, cycles a granted requester may hold req_valid low mid-burst before the grant is revoked

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of the requester's burst
req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i]
tx_data  out  8  byte to the UART TX core
new_tx_data  out  1  one-cycle start strobe to the UART
tx_busy  in  1  UART busy
grant_valid  out  1  a burst is in progress
grant_id  out  $clog2(NUM_REQ) (min 1)  current owner
stall_err  out  1  sticky flag: a grant was revoked by stall timeout
clear_err  in  1  clears stall_err

Behaviour:
- Interface decision: one clock (clk); rst is asynchronous, active-high.
- Reset values: state=IDLE; tx_data=0; new_tx_data=0; req_ready=0; grant_valid=0; grant_id=0; stall_err=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered or decoded from the registered state. req_ready is combinational from state, hdr_pending and grant_id only; it never depends on req_valid.
- IDLE: grant_valid=0. If any req_valid is high, pick round-robin: the first set bit searching from last_grant+1, wrapping modulo NUM_REQ. Then set grant_id, grant_valid=1, burst_cnt=0, stall_cnt=0, hdr_pending=HEADER_EN, and go to LOAD.
- LOAD with hdr_pending=1: tx_data<=header, is_hdr<=1, hdr_pending<=0, go to PULSE. req_ready stays 0.
- LOAD with hdr_pending=0: req_ready[grant_id]=1, all other bits 0.
  - If req_valid[grant_id]: tx_data<=byte, last_q<=req_last[grant_id], is_hdr<=0, burst_cnt++, stall_cnt<=0, go to PULSE.
  - Otherwise stall_cnt++. When stall_cnt reaches STALL_MAX-1: stall_err<=1, last_grant<=grant_id, go to IDLE.
- PULSE: new_tx_data=1 for exactly this cycle, then GAP.
- GAP: one cycle so the UART can raise tx_busy, then WAIT.
- WAIT: stay until tx_busy==0, then NEXT.
- NEXT:
  - If is_hdr, go to LOAD.
  - Else if last_q or burst_cnt==MAX_BURST: last_grant<=grant_id, go to IDLE.
  - Else go to LOAD.
- Latency and throughput: a new request is seen in IDLE; the header strobe comes 2 cycles later. Each byte takes at least 5 cycles plus the UART busy time.
- A requester must hold req_valid and req_data stable until accepted. A requester that drops req_valid before acceptance is simply not served; this is not an error.
- The mid-burst grant is never pre-empted by other requesters, except by stall timeout or reaching MAX_BURST.
- The first payload byte is accepted in LOAD even if it carries req_last, so a 1-byte burst is legal. With HEADER_EN it sends 2 UART bytes.
- If MAX_BURST is reached without req_last, the burst is released and re-arbitrated. If the same requester is still requesting and is the only one, it gets a fresh grant and a new header.
- clear_err has priority over a same-cycle stall_err set; the set is lost.
- rst asserted mid-burst: everything returns to reset values immediately. Any UART byte already strobed is not tracked, and no further strobe is issued.
- tx_busy high while in IDLE or LOAD has no effect.

Test Plan:
1. Single requester: req 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), HEADER_EN=1, UART busy for 10 cycles per byte -> UART sees 0xA0, 0x11, 0x22, 0x33, exactly 4 new_tx_data pulses, then grant_valid=0.
2. Round-robin: req 0 and req 1 both hold 2-byte bursts continuously -> order is hdr A0, r0, r0, hdr A1, r1, r1, hdr A0, and so on; no requester is served twice in a row.
3. MAX_BURST=4, req 1 streams 6 bytes with last on the 6th -> A1 + 4 bytes, release, A1 + 2 bytes; total 8 strobes.
4. Stall: STALL_MAX=8, req 0 drops valid after 1 byte -> after 8 LOAD cycles, stall_err=1, grant moves to pending req 1; clear_err then returns stall_err to 0.
5. Backpressure: tx_busy held high for 50 cycles after a strobe -> no second strobe until 2 cycles after tx_busy falls; req_ready stays 0 throughout WAIT.
6. Reset mid-burst: assert rst in WAIT -> on the same edge, new_tx_data=0, grant_valid=0, req_ready=0. After release, req 0 wins first arbitration.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART TX arbiter.
// slave is the arbiter's view; master is the requesters plus UART core.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 stall_err;
  logic                 clear_err;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_busy,
    input  clear_err,
    output req_ready,
    output tx_data,
    output new_tx_data,
    output grant_valid,
    output grant_id,
    output stall_err
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_busy,
    output clear_err,
    input  req_ready,
    input  tx_data,
    input  new_tx_data,
    input  grant_valid,
    input  grant_id,
    input  stall_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART transmitter between requesters.
// Optional header byte per burst; grants end on last, MAX_BURST or stall.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16,
  parameter int HEADER_EN = 1,
  parameter int STALL_MAX = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int SCW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    GAP,
    WAIT,
    NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           hdr_pending_q, hdr_pending_d;
  logic           is_hdr_q, is_hdr_d;
  logic           last_q, last_d;
  logic           stall_err_q, stall_err_d;
  logic           stall_set;

  logic [2:0]     gid3;
  logic [7:0]     hdr_byte;
  logic [7:0]     cur_byte;
  logic           cur_valid;
  logic           cur_last;
  logic [NUM_REQ-1:0] ready;

  // First set bit strictly after 'last', wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IDW-1:0]     last
  );
    logic [IDW-1:0] pick;
    logic [IDW-1:0] ix;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      ix  = IDW'(idx);
      if (!found && v[ix]) begin
        pick  = ix;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign gid3      = 3'(grant_id_q);
  assign hdr_byte  = {4'hA, 1'b0, gid3};
  assign cur_byte  = bus.req_data[{grant_id_q, 3'b000} +: 8];
  assign cur_valid = bus.req_valid[grant_id_q];
  assign cur_last  = bus.req_last[grant_id_q];

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    hdr_pending_d = hdr_pending_q;
    is_hdr_d      = is_hdr_q;
    last_d        = last_q;
    stall_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_id_d    = rr_pick(bus.req_valid, last_grant_q);
          burst_cnt_d   = '0;
          stall_cnt_d   = '0;
          hdr_pending_d = (HEADER_EN != 0);
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (hdr_pending_q) begin
          tx_data_d     = hdr_byte;
          is_hdr_d      = 1'b1;
          hdr_pending_d = 1'b0;
          state_d       = PULSE;
        end else if (cur_valid) begin
          tx_data_d   = cur_byte;
          last_d      = cur_last;
          is_hdr_d    = 1'b0;
          burst_cnt_d = burst_cnt_q + BCW'(1);
          stall_cnt_d = '0;
          state_d     = PULSE;
        end else if (stall_cnt_q == SCW'(STALL_MAX - 1)) begin
          stall_set    = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + SCW'(1);
        end
      end
      PULSE: state_d = GAP;
      GAP:   state_d = WAIT;
      WAIT: begin
        if (!bus.tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (is_hdr_q) begin
          state_d = LOAD;
        end else if (last_q || burst_cnt_q == BCW'(MAX_BURST)) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // A clear in the same cycle as a timeout wins; that timeout is dropped.
    stall_err_d = bus.clear_err ? 1'b0 : (stall_err_q | stall_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      burst_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      hdr_pending_q <= 1'b0;
      is_hdr_q      <= 1'b0;
      last_q        <= 1'b0;
      stall_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      hdr_pending_q <= hdr_pending_d;
      is_hdr_q      <= is_hdr_d;
      last_q        <= last_d;
      stall_err_q   <= stall_err_d;
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == LOAD && !hdr_pending_q) ready[grant_id_q] = 1'b1;
  end

  assign bus.req_ready   = ready;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = (state_q == PULSE);
  assign bus.grant_valid = (state_q != IDLE);
  assign bus.grant_id    = grant_id_q;
  assign bus.stall_err   = stall_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: queued burst streams predict the UART byte sequence.
// Monitor pops expectations on every new_tx_data strobe.
module tb_uart_tx_arbiter;
  localparam int NR = 3;
  localparam int MB = 4;
  localparam int ST = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  typedef struct {
    logic [7:0] d;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .MAX_BURST(MB),
    .HEADER_EN(1),
    .STALL_MAX(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   fall_cyc = -100;
  int   busy_mode = 0;
  int   m_last = NR - 1;
  ent_t drv_q[NR][$];
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    return e;
  endfunction

  function automatic bit drv_empty();
    for (int i = 0; i < NR; i++)
      if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: round-robin over requesters holding data; each grant is
  // a header then bytes until last flag, MB bytes, or the stream dries up.
  task automatic build_expect(output bit stall);
    ent_t mq[NR][$];
    ent_t e;
    exp_t x;
    int   g;
    int   n;
    stall = 1'b0;
    for (int i = 0; i < NR; i++) mq[i] = drv_q[i];
    while (1) begin
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (m_last + k) % NR;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g < 0) break;
      x.d = 8'hA0 | 8'(g);
      x.id = g;
      exp_q.push_back(x);
      n = 0;
      while (1) begin
        e = mq[g].pop_front();
        x.d = e.d;
        x.id = g;
        exp_q.push_back(x);
        n++;
        if (e.l) break;
        if (n == MB) break;
        if (mq[g].size() == 0) begin
          stall = 1'b1;
          break;
        end
      end
      m_last = g;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requesters: present the head of each queue, pop on handshake.
  initial begin
    logic [NR-1:0] fire;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        bus.req_valid[i] = (drv_q[i].size() > 0);
        bus.req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0].d : 8'h00;
        bus.req_last[i] = (drv_q[i].size() > 0) ? drv_q[i][0].l : 1'b0;
      end
    end
  end

  // UART core: busy from the cycle after the strobe for a chosen length.
  initial begin
    int len;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.new_tx_data) begin
        len = (busy_mode == 1) ? 10 :
              (busy_mode == 2) ? 50 : int'($urandom_range(0, 12));
        if (len > 0) begin
          @(posedge clk);
          #1;
          bus.tx_busy = 1'b1;
          repeat (len) @(posedge clk);
          #1;
          bus.tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.tx_busy) chk("ready_while_busy", 32'(bus.req_ready), 0);
        if (bus.new_tx_data) begin
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_strobe: got %0h want none", bus.tx_data);
          end else begin
            x = exp_q.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(x.d));
            chk("grant_id", 32'(bus.grant_id), x.id);
            chk("strobe_gap", 32'(cyc - fall_cyc >= 2), 1);
          end
        end
      end
    end
  end

  task automatic run_phase(input string nm);
    bit st;
    int n;
    build_expect(st);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !bus.grant_valid && drv_empty()) &&
               n < 3000);
    if (n >= 3000) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NR; i++) drv_q[i].delete();
    end
    chk({nm, "_stall_err"}, 32'(bus.stall_err), 32'(st));
    if (bus.stall_err) begin
      bus.clear_err = 1'b1;
      @(negedge clk);
      bus.clear_err = 1'b0;
      chk({nm, "_clear_err"}, 32'(bus.stall_err), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int n;
    bus.clear_err = 1'b0;
    #2;
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_strobe", 32'(bus.new_tx_data), 0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_stall_err", 32'(bus.stall_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    busy_mode = 1;
    drv_q[0].push_back(mk(8'h11, 1'b0));
    drv_q[0].push_back(mk(8'h22, 1'b0));
    drv_q[0].push_back(mk(8'h33, 1'b1));
    run_phase("single");

    busy_mode = 0;
    for (int b = 0; b < 3; b++) begin
      drv_q[0].push_back(mk(8'(2*b + 1), 1'b0));
      drv_q[0].push_back(mk(8'(2*b + 2), 1'b1));
      drv_q[1].push_back(mk(8'(8'h81 + 2*b), 1'b0));
      drv_q[1].push_back(mk(8'(8'h82 + 2*b), 1'b1));
    end
    run_phase("round_robin");

    for (int k = 0; k < 6; k++) drv_q[1].push_back(mk(8'(8'hC1 + k), k == 5));
    run_phase("max_burst");

    drv_q[0].push_back(mk(8'h5A, 1'b0));
    drv_q[1].push_back(mk(8'h6B, 1'b0));
    drv_q[1].push_back(mk(8'h6C, 1'b1));
    run_phase("stall");

    busy_mode = 2;
    drv_q[2].push_back(mk(8'hE1, 1'b0));
    drv_q[2].push_back(mk(8'hE2, 1'b1));
    run_phase("backpressure");

    busy_mode = 0;
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < NR; i++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int len;
          bit stl;
          len = $urandom_range(1, 6);
          stl = (b == nb - 1) && ($urandom_range(0, 5) == 0);
          for (int k = 0; k < len; k++)
            drv_q[i].push_back(mk(8'($urandom), (k == len - 1) && !stl));
        end
      end
      run_phase("random");
    end

    busy_mode = 2;
    for (int k = 0; k < 5; k++) drv_q[0].push_back(mk(8'(8'h40 + k), k == 4));
    drv_q[1].push_back(mk(8'h50, 1'b1));
    build_expect(st);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.grant_valid && bus.tx_busy) && n < 200);
    chk("reach_wait", 32'(n < 200), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_strobe", 32'(bus.new_tx_data), 0);
    chk("midrst_grant_valid", 32'(bus.grant_valid), 0);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_tx_data", 32'(bus.tx_data), 0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) drv_q[i].delete();
    m_last = NR - 1;
    n = 0;
    while (bus.tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_mode = 0;
    drv_q[2].push_back(mk(8'h72, 1'b1));
    drv_q[1].push_back(mk(8'h61, 1'b1));
    drv_q[0].push_back(mk(8'h70, 1'b0));
    drv_q[0].push_back(mk(8'h71, 1'b1));
    run_phase("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
